// File: rtl/vx_fifo_queue_mc.sv
// vx_fifo_queue_mc: multi-channel FIFO. NUM_QUEUES independent SIZE-deep
// queues share one storage array of NUM_QUEUES*SIZE words addressed as
// {qid, ptr}. The block accepts one push and one pop per cycle, and each can
// target any channel. Each channel has its own flags, occupancy and
// synchronous flush.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   push/push_qid/data_in write data_in to the tail of channel push_qid
//   pop/pop_qid           remove the head of channel pop_qid
//   data_out              head of channel pop_qid (combinational on pop_qid)
//   flush[q]              clear channel q at the next edge
//   empty/alm_empty/full/alm_full[q]  registered per-channel flags
//   size[q*SIZEW +: SIZEW]            per-channel occupancy

// Per-channel pointer/count/flag state. The flags are registered and are
// computed from the next count, so there is no combinational path from
// push/pop to the flag outputs.
module vx_fifo_queue_mc_ch #(
  parameter int SIZE      = 4,
  parameter int ALM_FULL  = SIZE - 1,
  parameter int ALM_EMPTY = 1,
  parameter int ADDRW     = 2,
  parameter int SIZEW     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  output logic [ADDRW-1:0] wr_ptr,
  output logic [ADDRW-1:0] rd_ptr,
  output logic [SIZEW-1:0] count,
  output logic             empty,
  output logic             alm_empty,
  output logic             full,
  output logic             alm_full
);

  logic [SIZEW-1:0] cnt_n;

  always_comb begin
    cnt_n = count;
    case ({push, pop})
      2'b10:   cnt_n = count + SIZEW'(1);
      2'b01:   cnt_n = count - SIZEW'(1);
      default: cnt_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      alm_empty <= (ALM_EMPTY >= 0);
      full      <= 1'b0;
      alm_full  <= (ALM_FULL <= 0);
    end else begin
      // SIZE is a power of two, so the natural pointer overflow is the wrap.
      if (push) wr_ptr <= wr_ptr + ADDRW'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDRW'(1);
      count     <= cnt_n;
      empty     <= (cnt_n == '0);
      alm_empty <= (cnt_n <= SIZEW'(ALM_EMPTY));
      full      <= (cnt_n == SIZEW'(SIZE));
      alm_full  <= (cnt_n >= SIZEW'(ALM_FULL));
    end
  end

endmodule

module vx_fifo_queue_mc #(
  parameter int DATAW      = 1,
  parameter int SIZE       = 4,
  parameter int NUM_QUEUES = 4,
  parameter int ALM_FULL   = SIZE - 1,
  parameter int ALM_EMPTY  = 1,
  parameter int ADDRW      = $clog2(SIZE),
  parameter int QIDW       = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
  parameter int SIZEW      = $clog2(SIZE + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [QIDW-1:0]             push_qid,
  input  logic [DATAW-1:0]            data_in,
  input  logic                        pop,
  input  logic [QIDW-1:0]             pop_qid,
  output logic [DATAW-1:0]            data_out,
  input  logic [NUM_QUEUES-1:0]       flush,
  output logic [NUM_QUEUES-1:0]       empty,
  output logic [NUM_QUEUES-1:0]       alm_empty,
  output logic [NUM_QUEUES-1:0]       full,
  output logic [NUM_QUEUES-1:0]       alm_full,
  output logic [NUM_QUEUES*SIZEW-1:0] size
);

  localparam int AW = QIDW + ADDRW;

  typedef struct packed {
    logic             vld;
    logic [QIDW-1:0]  qid;
    logic [DATAW-1:0] data;
  } push_req_t;

  push_req_t req;
  logic [QIDW-1:0] rq;

  // With a single channel the qid inputs carry no information, so both qids are forced to 0.
  assign req.vld  = push;
  assign req.qid  = (NUM_QUEUES == 1) ? '0 : push_qid;
  assign req.data = data_in;
  assign rq       = (NUM_QUEUES == 1) ? '0 : pop_qid;

  logic [NUM_QUEUES-1:0][ADDRW-1:0] wr_ptr_a, rd_ptr_a;
  logic [NUM_QUEUES-1:0][SIZEW-1:0] count_a;

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_ch
    logic ch_push, ch_pop;
    assign ch_push = req.vld && (req.qid == QIDW'(q));
    assign ch_pop  = pop && (rq == QIDW'(q));

    vx_fifo_queue_mc_ch #(
      .SIZE(SIZE), .ALM_FULL(ALM_FULL), .ALM_EMPTY(ALM_EMPTY),
      .ADDRW(ADDRW), .SIZEW(SIZEW)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush[q]),
      .push     (ch_push),
      .pop      (ch_pop),
      .wr_ptr   (wr_ptr_a[q]),
      .rd_ptr   (rd_ptr_a[q]),
      .count    (count_a[q]),
      .empty    (empty[q]),
      .alm_empty(alm_empty[q]),
      .full     (full[q]),
      .alm_full (alm_full[q])
    );

    assign size[q*SIZEW +: SIZEW] = count_a[q];
  end

  // Shared LUTRAM: one write port, one asynchronous read port, not reset.
  logic [DATAW-1:0] mem [NUM_QUEUES*SIZE];
  logic [AW-1:0]    waddr, raddr;

  assign waddr = {req.qid, wr_ptr_a[req.qid]};
  assign raddr = {rq, rd_ptr_a[rq]};

  // A flushed or reset channel drops its push, so skip the write as well.
  always_ff @(posedge clk) begin
    if (req.vld && !reset && !flush[req.qid])
      mem[waddr] <= req.data;
  end

  // Reads the current head, so a same-cycle push to the same channel does not appear here.
  assign data_out = mem[raddr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (req.vld && !flush[req.qid])
        assert (!full[req.qid]) else $error("push to full channel %0d", req.qid);
      if (pop && !flush[rq])
        assert (!empty[rq]) else $error("pop from empty channel %0d", rq);
    end
  end

endmodule

// File: tb/tb_vx_fifo_queue_mc.sv
module tb_vx_fifo_queue_mc;
  localparam int DW = 8, SZ = 4, NQ = 4, SW = 3;

  logic          clk = 0;
  logic          reset;
  logic          push, pop;
  logic [1:0]    push_qid, pop_qid;
  logic [DW-1:0] data_in, data_out;
  logic [NQ-1:0] flush, empty, alm_empty, full, alm_full;
  logic [NQ*SW-1:0] size_flat;

  int n_err = 0, n_chk = 0;

  // Reference model: one queue of values per channel.
  logic [DW-1:0] mq [NQ][$];

  vx_fifo_queue_mc #(.DATAW(DW), .SIZE(SZ), .NUM_QUEUES(NQ)) dut (
    .clk(clk), .reset(reset), .push(push), .push_qid(push_qid), .data_in(data_in),
    .pop(pop), .pop_qid(pop_qid), .data_out(data_out), .flush(flush),
    .empty(empty), .alm_empty(alm_empty), .full(full), .alm_full(alm_full),
    .size(size_flat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags();
    for (int q = 0; q < NQ; q++) begin
      int s = mq[q].size();
      chk($sformatf("empty[%0d]", q),     32'(empty[q]),     32'(s == 0));
      chk($sformatf("alm_empty[%0d]", q), 32'(alm_empty[q]), 32'(s <= 1));
      chk($sformatf("full[%0d]", q),      32'(full[q]),      32'(s == SZ));
      chk($sformatf("alm_full[%0d]", q),  32'(alm_full[q]),  32'(s >= SZ - 1));
      chk($sformatf("size[%0d]", q),      32'(size_flat[q*SW +: SW]), 32'(s));
    end
  endtask

  // Called just after a rising edge: drive, check head mid-cycle, clock, update model, check flags.
  task automatic do_cycle(input bit ps, input int pq, input logic [DW-1:0] d,
                          input bit pp, input int oq, input logic [NQ-1:0] fl);
    push = ps; push_qid = 2'(pq); data_in = d;
    pop = pp;  pop_qid = 2'(oq);  flush = fl;
    @(negedge clk);
    if (!reset && mq[oq].size() > 0) chk("data_out", 32'(data_out), 32'(mq[oq][0]));
    @(posedge clk);
    if (reset) begin
      for (int q = 0; q < NQ; q++) mq[q].delete();
    end else begin
      for (int q = 0; q < NQ; q++) begin
        if (fl[q]) mq[q].delete();
        else begin
          if (pp && oq == q) void'(mq[q].pop_front());
          if (ps && pq == q) mq[q].push_back(d);
        end
      end
    end
    #1;
    push = 0; pop = 0; flush = '0;
    chk_flags();
  endtask

  initial begin
    reset = 1; push = 0; pop = 0; push_qid = 0; pop_qid = 0; data_in = 0; flush = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    chk("rst_empty", 32'(empty), 32'hF);
    chk("rst_alm_empty", 32'(alm_empty), 32'hF);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_alm_full", 32'(alm_full), 32'h0);
    chk("rst_size", 32'(size_flat), 32'h0);
    do_cycle(0, 0, 0, 0, 0, 0);

    // Fill q2 to full.
    do_cycle(1, 2, 8'hA, 0, 0, 0);
    do_cycle(1, 2, 8'hB, 0, 0, 0);
    do_cycle(1, 2, 8'hC, 0, 0, 0);
    chk("alm_full2_after3", 32'(alm_full[2]), 32'h1);
    chk("full2_after3", 32'(full[2]), 32'h0);
    do_cycle(1, 2, 8'hD, 0, 0, 0);
    chk("full2", 32'(full[2]), 32'h1);
    chk("size2", 32'(size_flat[2*SW +: SW]), 32'd4);
    chk("others_empty", 32'(empty & 4'b1011), 32'hB);
    // Drain q2 and check the order.
    for (int i = 0; i < 4; i++) begin
      pop_qid = 2; #1;
      chk("q2_order", 32'(data_out), 32'(8'hA + i));
      do_cycle(0, 0, 0, 1, 2, 0);
    end
    chk("empty2", 32'(empty[2]), 32'h1);

    // Interleave q0/q3.
    do_cycle(1, 0, 8'h11, 0, 0, 0);
    do_cycle(1, 3, 8'h33, 0, 0, 0);
    pop_qid = 3; #1; chk("il_q3", 32'(data_out), 32'h33);
    do_cycle(0, 0, 0, 1, 3, 0);
    pop_qid = 0; #1; chk("il_q0", 32'(data_out), 32'h11);
    do_cycle(0, 0, 0, 1, 0, 0);

    // Same-cycle push/pop on q1 with count 2.
    do_cycle(1, 1, 8'h1, 0, 0, 0);
    do_cycle(1, 1, 8'h2, 0, 0, 0);
    pop_qid = 1; #1; chk("same_old_head", 32'(data_out), 32'h1);
    do_cycle(1, 1, 8'h5, 1, 1, 0);
    chk("same_count", 32'(size_flat[1*SW +: SW]), 32'd2);
    do_cycle(0, 0, 0, 1, 1, 0);
    pop_qid = 1; #1; chk("same_new", 32'(data_out), 32'h5);
    do_cycle(0, 0, 0, 1, 1, 0);

    // Wrap through q0: ten push/pop pairs, then ten overlapped pairs.
    for (int i = 0; i < 10; i++) begin
      do_cycle(1, 0, 8'(8'h40 + i), 0, 0, 0);
      do_cycle(0, 0, 0, 1, 0, 0);
    end
    do_cycle(1, 0, 8'h60, 0, 0, 0);
    for (int i = 1; i < 10; i++) do_cycle(1, 0, 8'(8'h60 + i), 1, 0, 0);
    do_cycle(0, 0, 0, 1, 0, 0);

    // Flush q1 with a same-cycle push to q1, then flush q1 alongside a push to q2.
    do_cycle(1, 1, 8'h71, 0, 0, 0);
    do_cycle(1, 1, 8'h72, 0, 0, 0);
    do_cycle(1, 1, 8'h73, 0, 0, 4'b0010);
    chk("flush_cnt1", 32'(size_flat[1*SW +: SW]), 32'd0);
    chk("flush_empty1", 32'(empty[1]), 32'h1);
    do_cycle(1, 2, 8'h74, 0, 0, 4'b0010);
    chk("flush_cnt2", 32'(size_flat[2*SW +: SW]), 32'd1);
    do_cycle(0, 0, 0, 1, 2, 0);

    // Reset mid-operation discards the in-flight push.
    do_cycle(1, 3, 8'h81, 0, 0, 0);
    reset = 1;
    do_cycle(1, 3, 8'h82, 0, 0, 0);
    reset = 0;
    chk("midrst_size", 32'(size_flat), 32'h0);

    // Random legal traffic.
    for (int i = 0; i < 400; i++) begin
      int pq = $urandom_range(0, NQ-1);
      int oq = $urandom_range(0, NQ-1);
      bit ps = ($urandom_range(0, 2) != 0) && (mq[pq].size() < SZ);
      bit pp = ($urandom_range(0, 1) != 0) && (mq[oq].size() > 0);
      logic [NQ-1:0] fl = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'h0;
      do_cycle(ps, pq, 8'($urandom), pp, oq, fl);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
